// File: rtl/rom_pkg.sv
// Shared constants for the rom block: default geometry and the lookup table
// contents loaded into storage at elaboration.
package rom_pkg;

  localparam int ROM_DATA_WIDTH = 16;
  localparam int ROM_ADDR_WIDTH = 4;
  localparam int ROM_WORDS      = 16;

  localparam logic [15:0] ROM_DEFAULT [0:ROM_WORDS-1] = '{
    16'h0103, 16'h5200, 16'he0b9, 16'h0412,
    16'h4839, 16'h0112, 16'h0377, 16'h0572,
    16'hcafe, 16'h6225, 16'h1447, 16'haeec,
    16'h52dd, 16'h1113, 16'h4444, 16'h5555
  };

endpackage

// File: rtl/rom.sv
// Synchronous read-only lookup table with one enabled, registered read port.
// Storage is named mem so benches can preload it hierarchically before use.
module rom
  import rom_pkg::*;
#(
  parameter int DATA_WIDTH = ROM_DATA_WIDTH,
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  // Contents are fixed at elaboration; words beyond the default table read as zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i < ROM_WORDS) begin
        mem[i] = DATA_WIDTH'(ROM_DEFAULT[i]);
      end else begin
        mem[i] = '0;
      end
    end
  end

  always_comb begin
    data_d = data_q;
    if (r_en) begin
      data_d = mem[addr];
    end
  end

  // Reset has priority over a read on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: tb/tb_rom.sv
// Self-checking bench for rom: directed scenarios plus randomized reads
// compared against a table-based reference model.
module tb_rom;

  logic        clk;
  logic        rst;
  logic        r_en;
  logic [3:0]  addr;
  logic [15:0] data;

  logic [15:0] refMem [0:15];
  logic [15:0] expData;
  int          testsRun;
  int          testsFailed;

  rom dut (
    .clk  (clk),
    .rst  (rst),
    .r_en (r_en),
    .addr (addr),
    .data (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs away from the active edge, take one rising edge, then
  // advance the reference model: reset clears, enabled read fetches, else hold.
  task automatic cycle(input logic rstIn, input logic enIn, input logic [3:0] addrIn);
    @(negedge clk);
    rst  = rstIn;
    r_en = enIn;
    addr = addrIn;
    @(posedge clk);
    #1;
    if (rstIn)     expData = 16'h0000;
    else if (enIn) expData = refMem[addrIn];
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 4'd8);
      testsRun++;
      if (data !== 16'h0000) begin
        testsFailed++;
        $display("[TB] FAIL reset_edge%0d: data=%h expected=0000", i, data);
      end
    end
    cycle(1'b0, 1'b1, 4'd8);
    testsRun++;
    if (data !== 16'hcafe) begin
      testsFailed++;
      $display("[TB] FAIL reset_release: data=%h expected=cafe", data);
    end
  endtask

  task automatic test_enable();
    cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 4'd0);
    testsRun++;
    if (data !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL enable_gated: data=%h expected=0000", data);
    end
    cycle(1'b0, 1'b1, 4'd0);
    testsRun++;
    if (data !== 16'h0103) begin
      testsFailed++;
      $display("[TB] FAIL enable_read: data=%h expected=0103", data);
    end
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 16; a++) begin
      if (a == 9) begin
        cycle(1'b1, 1'b1, 4'd9);
        testsRun++;
        if (data !== 16'h0000) begin
          testsFailed++;
          $display("[TB] FAIL midstream_reset: data=%h expected=0000", data);
        end
      end
      cycle(1'b0, 1'b1, 4'(a));
      testsRun++;
      if (data !== expData) begin
        testsFailed++;
        $display("[TB] FAIL sweep_addr%0d: data=%h expected=%h", a, data, expData);
      end
    end
  endtask

  task automatic test_hold();
    cycle(1'b0, 1'b1, 4'd11);
    testsRun++;
    if (data !== 16'haeec) begin
      testsFailed++;
      $display("[TB] FAIL hold_read11: data=%h expected=aeec", data);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 4'd2);
      testsRun++;
      if (data !== 16'haeec) begin
        testsFailed++;
        $display("[TB] FAIL hold_cycle%0d: data=%h expected=aeec", i, data);
      end
    end
    cycle(1'b0, 1'b1, 4'd2);
    testsRun++;
    if (data !== 16'he0b9) begin
      testsFailed++;
      $display("[TB] FAIL hold_resume: data=%h expected=e0b9", data);
    end
  endtask

  task automatic test_preload();
    cycle(1'b0, 1'b1, 4'd5);
    testsRun++;
    if (data !== 16'hbeef) begin
      testsFailed++;
      $display("[TB] FAIL preload_addr5: data=%h expected=beef", data);
    end
    cycle(1'b0, 1'b1, 4'd4);
    testsRun++;
    if (data !== 16'h4839) begin
      testsFailed++;
      $display("[TB] FAIL preload_addr4: data=%h expected=4839", data);
    end
  endtask

  // Wrap 15 -> 0, then wiggle addr between edges: data must not follow it.
  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 4'd15);
    cycle(1'b0, 1'b1, 4'd0);
    testsRun++;
    if (data !== 16'h0103) begin
      testsFailed++;
      $display("[TB] FAIL wrap_15_to_0: data=%h expected=0103", data);
    end
    #1 addr = 4'd13;
    #1 r_en = 1'b1;
    testsRun++;
    if (data !== 16'h0103) begin
      testsFailed++;
      $display("[TB] FAIL addr_change_between_edges: data=%h expected=0103", data);
    end
    @(posedge clk);
    #1;
    expData = refMem[13];
    testsRun++;
    if (data !== 16'h1113) begin
      testsFailed++;
      $display("[TB] FAIL addr_sampled_at_edge: data=%h expected=1113", data);
    end
  endtask

  task automatic test_random();
    logic       rRst;
    logic       rEn;
    logic [3:0] rAddr;
    for (int i = 0; i < 300; i++) begin
      rRst  = ($urandom_range(0, 19) == 0);
      rEn   = $urandom_range(0, 1) == 1;
      rAddr = 4'($urandom_range(0, 15));
      cycle(rRst, rEn, rAddr);
      testsRun++;
      if (data !== expData) begin
        testsFailed++;
        $display("[TB] FAIL random_op%0d rst=%0b en=%0b addr=%0d: data=%h expected=%h",
                 i, rRst, rEn, rAddr, data, expData);
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    expData     = 16'h0000;
    rst         = 1'b1;
    r_en        = 1'b0;
    addr        = 4'd0;
    refMem = '{16'h0103, 16'h5200, 16'he0b9, 16'h0412,
               16'h4839, 16'h0112, 16'h0377, 16'h0572,
               16'hcafe, 16'h6225, 16'h1447, 16'haeec,
               16'h52dd, 16'h1113, 16'h4444, 16'h5555};
    // Preload after the design's own initialisation but before any edge.
    #1;
    dut.mem[5] = 16'hbeef;
    refMem[5]  = 16'hbeef;

    test_reset();
    test_enable();
    test_sweep();
    test_hold();
    test_preload();
    test_back_to_back();
    test_random();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
